// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: scan-code constants, frame FSM states, event record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

   // Special scan codes recognised by the receiver
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;   // keyboard self-test passed
   localparam logic [7:0] PS2_BREAK  = 8'hF0;   // key-release prefix
   localparam logic [7:0] PS2_EXT    = 8'hE0;   // extended-key prefix

   // Frame FSM: start bit is consumed in IDLE, then 8 data bits, parity, stop
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   // Queued key event. "release" is a reserved word, hence "released".
   typedef struct packed {
      logic       extended;
      logic       released;
      logic [7:0] code;
   } ps2_evt_t;

   // Odd parity: data bits plus parity bit must hold an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// Synchroniser + glitch filter for one PS/2 line (ps2_clk or ps2_data).
// Latency: 2 sync flops + FILTER_LEN samples before a level change reaches dout.
// Backpressure: none; free-running. Ports: clk, rst (sync, active-high), din (async), dout (filtered).
module ps2_rx_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam logic [4:0] CNT_MAX = 5'(FILTER_LEN - 1);

   logic       sync1_q;
   logic       sync2_q;
   logic       filt_q;
   logic [4:0] cnt_q;

   // Reset to 1 so an idle (pulled-up) bus never looks like an edge.
   // The filtered level only moves after FILTER_LEN consecutive samples
   // that disagree with it; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         if (sync2_q == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            filt_q <= sync2_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 5'd1;
         end
      end
   end

   assign dout = filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: deserialises frames, folds E0/F0 prefixes into key events, queues them.
// Latency: event visible one clk after the stop-bit sample (ps2 edge + 2 sync + FILTER_LEN to that sample).
// Backpressure: show-ahead FIFO with evt_valid/evt_ready; when full, new events are dropped and overflow sticks.
//
// Ports: clk/rst (sync, active-high); ps2_clk/ps2_data (async keyboard lines);
//        evt_valid/evt_ready/evt_code/evt_release/evt_extended (event stream);
//        bat_ok/frame_err/parity_err (1-cycle pulses); overflow (sticky until rst).
// Build option: define PS2_RX_PARITY_EN to check odd parity and drop bad frames;
//        otherwise the parity bit is ignored and parity_err is tied low.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_release,
   output logic       evt_extended,
   output logic       bat_ok,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overflow
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Line conditioning and falling-edge detect
   // ------------------------------------------------------------------
   logic filt_clk;
   logic filt_data;
   logic filt_clk_q;
   logic fall;

   ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk  (clk),
      .rst  (rst),
      .din  (ps2_clk),
      .dout (filt_clk)
   );

   ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk  (clk),
      .rst  (rst),
      .din  (ps2_data),
      .dout (filt_data)
   );

   // Data is sampled combinationally in the same cycle the edge is seen
   assign fall = filt_clk_q & ~filt_clk;

   // ------------------------------------------------------------------
   // Frame FSM state
   // ------------------------------------------------------------------
   ps2_state_t       state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             ext_pend_q, ext_pend_d;
   logic             rel_pend_q, rel_pend_d;
   logic             tmo_hit;
   logic             byte_ok;
   logic             clr_pend;
   logic             frame_err_d;
   logic             parity_err_d;
   logic             bat_ok_d;
   logic             push_req;
   ps2_evt_t         push_evt;

`ifdef PS2_RX_PARITY_EN
   logic par_q, par_d;
`endif

   // Timeout: tmo_q counts clk cycles since the last edge of this frame
   assign tmo_hit = (state_q != ST_IDLE) && !fall && (tmo_q == TMO_LAST);

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      tmo_d        = tmo_q;
      byte_ok      = 1'b0;
      clr_pend     = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
`ifdef PS2_RX_PARITY_EN
      par_d        = par_q;
`endif

      if (state_q == ST_IDLE || fall) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      if (tmo_hit) begin
         state_d     = ST_IDLE;
         tmo_d       = '0;
         frame_err_d = 1'b1;
         clr_pend    = 1'b1;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               // Start bit must be 0; a stray edge with data high is reported
               if (!filt_data) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            ST_DATA: begin
               // LSB first: shift in from the top
               shreg_d   = {filt_data, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
`ifdef PS2_RX_PARITY_EN
               par_d = filt_data;
`endif
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!filt_data) begin
                  frame_err_d = 1'b1;
                  clr_pend    = 1'b1;
`ifdef PS2_RX_PARITY_EN
               end else if (!odd_parity_ok(shreg_q, par_q)) begin
                  parity_err_d = 1'b1;
                  clr_pend     = 1'b1;
`endif
               end else begin
                  byte_ok = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Byte classification: prefixes are absorbed, BAT is signalled,
   // everything else becomes an event carrying the pending prefixes.
   // ------------------------------------------------------------------
   always_comb begin
      ext_pend_d = ext_pend_q;
      rel_pend_d = rel_pend_q;
      bat_ok_d   = 1'b0;
      push_req   = 1'b0;
      push_evt   = '{extended: ext_pend_q, released: rel_pend_q, code: shreg_q};

      if (byte_ok) begin
         if (shreg_q == PS2_EXT) begin
            ext_pend_d = 1'b1;
         end else if (shreg_q == PS2_BREAK) begin
            rel_pend_d = 1'b1;
         end else if (shreg_q == PS2_BAT_OK && !ext_pend_q && !rel_pend_q) begin
            bat_ok_d = 1'b1;
         end else begin
            // Flags are consumed even if the FIFO drops the event
            push_req   = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
         end
      end else if (clr_pend) begin
         ext_pend_d = 1'b0;
         rel_pend_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO (show-ahead)
   // ------------------------------------------------------------------
   ps2_evt_t         mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] fifo_cnt_q;
   logic             fifo_full;
   logic             pop;
   logic             push_acc;
   ps2_evt_t         head;

   assign fifo_full = (fifo_cnt_q == DEPTH_CNT);
   assign pop       = evt_valid & evt_ready;
   // When full, a push is only taken if the head leaves in the same cycle
   assign push_acc  = push_req & (~fifo_full | pop);
   assign head      = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr_q] <= push_evt;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   logic bat_ok_q;
   logic frame_err_q;
   logic parity_err_q;
   logic overflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_clk_q   <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         tmo_q        <= '0;
         ext_pend_q   <= 1'b0;
         rel_pend_q   <= 1'b0;
         bat_ok_q     <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
      end else begin
         filt_clk_q   <= filt_clk;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         tmo_q        <= tmo_d;
         ext_pend_q   <= ext_pend_d;
         rel_pend_q   <= rel_pend_d;
         bat_ok_q     <= bat_ok_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;

         if (push_req && fifo_full && !pop) begin
            overflow_q <= 1'b1;
         end

         if (push_acc) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push_acc && !pop) begin
            fifo_cnt_q <= fifo_cnt_q + 1'b1;
         end else if (pop && !push_acc) begin
            fifo_cnt_q <= fifo_cnt_q - 1'b1;
         end
      end
   end

`ifdef PS2_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
   assign parity_err = parity_err_q;
`else
   // Parity is never evaluated in this build
   assign parity_err = 1'b0;
   logic unused_perr;
   assign unused_perr = parity_err_q | parity_err_d;
`endif

   // ------------------------------------------------------------------
   // Outputs; the head is masked so outputs read 0 while the FIFO is empty
   // ------------------------------------------------------------------
   assign evt_valid    = (fifo_cnt_q != '0);
   assign evt_code     = evt_valid ? head.code     : 8'h00;
   assign evt_release  = evt_valid ? head.released : 1'b0;
   assign evt_extended = evt_valid ? head.extended : 1'b0;
   assign bat_ok       = bat_ok_q;
   assign frame_err    = frame_err_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of frame sequences plus hand-written corner cases.
module tb_ps2_receiver;

   localparam int HALF  = 20;    // clk cycles per ps2_clk half period
   localparam int TMO   = 2000;
   localparam int DEPTH = 8;
   // ps2_clk fall driven -> 2 sync flops -> 4 filter samples -> event registered
   localparam int LAT   = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_release;
   logic       evt_extended;
   logic       bat_ok;
   logic       frame_err;
   logic       parity_err;
   logic       overflow;

   ps2_receiver #(
      .FILTER_LEN    (4),
      .TIMEOUT_CYCLES(TMO),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_release  (evt_release),
      .evt_extended (evt_extended),
      .bat_ok       (bat_ok),
      .frame_err    (frame_err),
      .parity_err   (parity_err),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mark  = 0;
   int n_bat, n_ferr, n_perr;
   int first_vld, first_bat;

   typedef struct {
      int          nb;        // number of frames
      logic [23:0] bytes;     // frame k is bytes[8k +: 8]
      logic        flip;      // corrupt parity on every frame
      logic        exp_vld;
      logic        exp_ext;
      logic        exp_rel;
      logic [7:0]  exp_code;
      int          exp_bat;
      int          exp_perr;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // All time passes here; outputs are sampled 1ns after the rising edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bat_ok)     n_bat++;
         if (frame_err)  n_ferr++;
         if (parity_err) n_perr++;
         if (evt_valid && first_vld < 0) first_vld = cyc;
         if (bat_ok && first_bat < 0)    first_bat = cyc;
      end
   endtask

   task automatic clear_obs();
      n_bat = 0; n_ferr = 0; n_perr = 0; first_vld = -1; first_bat = -1;
   endtask

   task automatic clk_pulse(input logic d);
      ps2_data = d;
      tick(HALF);
      ps2_clk = 1'b0;
      mark = cyc;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   // nedges < 11 sends a truncated frame
   task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop, input int nedges);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ flip, b, 1'b0};
      for (int i = 0; i < nedges; i++) clk_pulse(bits[i]);
      ps2_data = 1'b1;
   endtask

   task automatic pop_chk(input string name, input logic e, input logic r, input logic [7:0] c);
      chk({name, ".valid"}, int'(evt_valid), 1);
      chk({name, ".code"}, int'(evt_code), int'(c));
      chk({name, ".ext"}, int'(evt_extended), int'(e));
      chk({name, ".rel"}, int'(evt_release), int'(r));
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
   endtask

   initial begin
      //           nb  bytes (first in LSB)  flip exp_vld ext rel code   bat perr
      vecs[0] = '{1, 24'h00001C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 0, 0};
      vecs[1] = '{3, 24'h74F0E0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h74, 0, 0};
      vecs[2] = '{1, 24'h0000AA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0};
      vecs[3] = '{2, 24'h00AAF0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 0, 0};
      vecs[4] = '{2, 24'h0012E0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 0, 0};
`ifdef PS2_RX_PARITY_EN
      vecs[5] = '{1, 24'h00001C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1};
`else
      vecs[5] = '{1, 24'h00001C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C, 0, 0};
`endif
      vecs[6] = '{3, 24'hAAE0F0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 0, 0};
      vecs[7] = '{1, 24'h00005A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 0, 0};

      // ---- reset state ----
      clear_obs();
      tick(3);
      chk("rst.evt_valid", int'(evt_valid), 0);
      chk("rst.evt_code", int'(evt_code), 0);
      chk("rst.evt_flags", int'({evt_extended, evt_release}), 0);
      chk("rst.pulses", int'({bat_ok, frame_err, parity_err}), 0);
      chk("rst.overflow", int'(overflow), 0);
      rst = 1'b0;
      tick(10);

      // ---- table-driven sequences ----
      for (int v = 0; v < 8; v++) begin
         clear_obs();
         for (int k = 0; k < vecs[v].nb; k++)
            send_frame(vecs[v].bytes[8*k +: 8], vecs[v].flip, 1'b1, 11);
         tick(30);
         chk($sformatf("v%0d.bat_ok", v), n_bat, vecs[v].exp_bat);
         chk($sformatf("v%0d.frame_err", v), n_ferr, 0);
         chk($sformatf("v%0d.parity_err", v), n_perr, vecs[v].exp_perr);
         chk($sformatf("v%0d.evt_valid", v), int'(evt_valid), int'(vecs[v].exp_vld));
         if (vecs[v].exp_vld) begin
            chk($sformatf("v%0d.latency", v), first_vld - mark, LAT);
            pop_chk($sformatf("v%0d", v), vecs[v].exp_ext, vecs[v].exp_rel, vecs[v].exp_code);
         end
         if (vecs[v].exp_bat != 0)
            chk($sformatf("v%0d.bat_latency", v), first_bat - mark, LAT);
         chk($sformatf("v%0d.empty", v), int'(evt_valid), 0);
      end

      // ---- timeout mid-frame: F0 pending, 4 data bits, then stall ----
      clear_obs();
      send_frame(8'hF0, 1'b0, 1'b1, 11);
      send_frame(8'h3C, 1'b0, 1'b1, 5);
      tick(TMO + 100);
      chk("tmo.frame_err", n_ferr, 1);
      chk("tmo.no_evt", int'(evt_valid), 0);
      clear_obs();
      send_frame(8'h29, 1'b0, 1'b1, 11);
      tick(30);
      chk("tmo.next.frame_err", n_ferr, 0);
      pop_chk("tmo.next", 1'b0, 1'b0, 8'h29);

      // ---- bad stop bit clears the pending release ----
      clear_obs();
      send_frame(8'hF0, 1'b0, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      tick(30);
      chk("stop.frame_err", n_ferr, 1);
      chk("stop.no_evt", int'(evt_valid), 0);
      send_frame(8'h15, 1'b0, 1'b1, 11);
      tick(30);
      pop_chk("stop.next", 1'b0, 1'b0, 8'h15);

      // ---- bad start bit ----
      clear_obs();
      clk_pulse(1'b1);
      tick(30);
      chk("start.frame_err", n_ferr, 1);
      chk("start.no_evt", int'(evt_valid), 0);

      // ---- reset mid-frame: no error, next frame clean ----
      clear_obs();
      send_frame(8'h00, 1'b0, 1'b1, 3);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(10);
      send_frame(8'h33, 1'b0, 1'b1, 11);
      tick(30);
      chk("midrst.frame_err", n_ferr, 0);
      pop_chk("midrst.next", 1'b0, 1'b0, 8'h33);

      // ---- overflow: DEPTH+1 frames with consumer stalled ----
      for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 11);
      tick(30);
      chk("ovf.flag", int'(overflow), 1);
      for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("ovf.e%0d", i), 1'b0, 1'b0, 8'h10 + 8'(i));
      tick(2);
      chk("ovf.drained", int'(evt_valid), 0);
      chk("ovf.sticky", int'(overflow), 1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      chk("ovf.cleared", int'(overflow), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
